trace_checker: RTL and testbench
================================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter TIME_DIGITS, default 4, giving the maximum number of decimal time digits.
REQ-002 SHALL have parameter REG_DIGITS, default 2, giving the maximum number of decimal register digits.
REQ-003 SHALL have parameters PC_LO/PC_HI, defaults 32'h3000/32'h4FFC, giving the inclusive legal PC range.
REQ-004 SHALL have parameters DM_LO/DM_HI, defaults 32'h0000/32'h2FFC, giving the inclusive legal data-memory address range.
REQ-005 SHALL have parameter GRF_MAX, default 31, giving the highest legal register index.
REQ-006 SHALL have the following ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-low (0 = reset).
- char_valid  in  1: char is consumed this cycle only when 1.
- char  in  8: ASCII input.
- freq  in  16: CPU MHz, power of two.
- format_type  out  2: 00 none/error, 01 register record, 10 memory record.
- error_code  out  4: semantic error flags.
- record_valid  out  1: one-cycle pulse per accepted record.
- rec_time  out  32, rec_pc  out  32, rec_dst  out  32, rec_data  out  32: fields of the last accepted record.
- rec_count  out  16, err_count  out  16: statistics.

Function
REQ-007 SHALL accept only this grammar: '^' dec{1..TIME_DIGITS} '@' hex{8} ':' ' '* ( '$' dec{1..REG_DIGITS} | '*' hex{8} ) ' '* '<' '=' ' '* hex{8} '#'.
- hex means 0-9 and a-f; uppercase is illegal.
REQ-008 SHALL use these FSM states: IDLE, CARET, TIME, AT, PC, COLON, DOLLAR, REG, STAR, ADDR, SP1, LT, EQ, DATA, DONE.
- All states advance only on cycles with char_valid=1.
- char_valid=0 holds all state, accumulators and outputs, except record_valid.
REQ-009 SHALL move to CARET on '^' from any state, discarding partial fields.
REQ-010 SHALL move to IDLE on any other character not allowed by the grammar.
REQ-011 SHALL treat a digit beyond TIME_DIGITS, beyond REG_DIGITS, or a 9th hex digit as illegal, moving to IDLE.
REQ-012 SHALL treat ':' or '#' after fewer than 8 hex digits as illegal, moving to IDLE.
REQ-013 SHALL accumulate time and register index as acc*10+digit, and PC/address/data as {acc[27:0],nibble}, in 32-bit registers cleared on entry to CARET.
REQ-014 SHALL, on accepting '#', on the next edge:
- enter DONE;
- load rec_* from the accumulators (rec_dst = register index or address);
- compute error_code;
- assert record_valid for exactly one cycle.
REQ-015 SHALL drive format_type as 01 or 10 only while in DONE, and 00 in every other state; error_code SHALL be 0 outside DONE.
REQ-016 SHALL leave DONE on the next accepted char: '^' goes to CARET, anything else goes to IDLE.
REQ-017 SHALL set error_code[0] when freq>=2 and (time & (freq/2-1)) != 0; with freq<2 the bit SHALL be 0.
REQ-018 SHALL set error_code[1] when PC < PC_LO, PC > PC_HI, or PC[1:0] != 0.
REQ-019 SHALL set error_code[2] (memory records only) when addr < DM_LO, addr > DM_HI, or addr[1:0] != 0.
REQ-020 SHALL set error_code[3] (register records only) when reg > GRF_MAX.
REQ-021 SHALL increment rec_count, wrapping modulo 2^16, on every record_valid.
REQ-022 SHALL increment err_count on every record_valid with a nonzero error code, saturating at 16'hFFFF.
REQ-023 SHALL keep rec_* unchanged until the next accepted record; malformed lines SHALL not modify rec_* or the counters.
REQ-024 SHALL sample freq in the cycle '#' is accepted.

Reset
REQ-025 SHALL, when reset=0 at a rising edge:
- go to IDLE;
- clear all accumulators, rec_*, rec_count, err_count, error_code, format_type and record_valid to 0.
REQ-026 SHALL let reset override char_valid and every state, including mid-line and DONE; no partial record survives.

Verification
REQ-027 SHALL pass these directed scenarios:
- freq=4, "^10@00003004: $5 <= 0000000a#" -> format_type=01, error_code=0, rec_time=10, rec_dst=5, rec_count=1.
- freq=4, "^7@00002ffe: *00003000 <= 12345678#" -> format_type=10, error_code=4'b0111, err_count=1.
- "^1@00003000: $32 <= 00000000#" with freq=1 -> error_code=4'b1000; "$123" -> IDLE, no record_valid.
- "^12@0000^5@00003000: $1 <= 00000001#" -> one record, rec_time=5; uppercase 'A' in data -> IDLE, counters unchanged.
- Valid line with char_valid=0 gaps of random length between chars -> results identical to the gapless case.
- reset=0 while in DATA -> all outputs 0; a following valid line is accepted normally.

Source files
------------

// File: rtl/trace_checker.sv
// -----------------------------------------------------------------------------
// trace_checker
//
// Parses a character stream of CPU trace lines of the form
//   ^<time>@<pc>: $<reg> <= <data>#     (register write record)
//   ^<time>@<pc>: *<addr> <= <data>#    (memory write record)
// with decimal time/register fields and 8-digit lowercase hex fields.
// Well-formed lines are published on rec_* with a one-cycle record_valid
// pulse and a set of semantic error flags; malformed lines are dropped.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low
//   char_valid   in   char is consumed only on cycles where this is 1
//   char         in   ASCII character
//   freq         in   CPU clock in MHz (power of two), sampled with '#'
//   format_type  out  00 none, 01 register record, 10 memory record (DONE only)
//   error_code   out  [0] time misaligned to freq/2, [1] bad PC,
//                     [2] bad memory address, [3] bad register index
//   record_valid out  one-cycle pulse per accepted record
//   rec_time/rec_pc/rec_dst/rec_data out  fields of the last accepted record
//   rec_count    out  accepted records, wraps
//   err_count    out  accepted records with any error flag, saturates
//   dbg_state    out  current parser state (for observation only)
//
// Handshake: a character is transferred on a rising edge where
// char_valid=1; there is no back-pressure. With char_valid=0 every register
// holds its value except record_valid, which always returns to 0.
// -----------------------------------------------------------------------------
module trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          REG_DIGITS  = 2,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4FFC,
    parameter logic [31:0] DM_LO       = 32'h0000_0000,
    parameter logic [31:0] DM_HI       = 32'h0000_2FFC,
    parameter int          GRF_MAX     = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char,
    input  logic [15:0] freq,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code,
    output logic        record_valid,
    output logic [31:0] rec_time,
    output logic [31:0] rec_pc,
    output logic [31:0] rec_dst,
    output logic [31:0] rec_data,
    output logic [15:0] rec_count,
    output logic [15:0] err_count,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CARET  = 4'd1,
        TIME   = 4'd2,
        AT     = 4'd3,
        PC     = 4'd4,
        COLON  = 4'd5,
        DOLLAR = 4'd6,
        REG    = 4'd7,
        STAR   = 4'd8,
        ADDR   = 4'd9,
        SP1    = 4'd10,
        LT     = 4'd11,
        EQ     = 4'd12,
        DATA   = 4'd13,
        DONE   = 4'd14
    } state_t;

    localparam logic [7:0] HEX_DIGITS = 8'd8;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;          // digits seen in the current field
    logic        is_mem_q, is_mem_d;    // '*' seen rather than '$'
    logic [31:0] time_q, time_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rec_time_q, rec_time_d;
    logic [31:0] rec_pc_q, rec_pc_d;
    logic [31:0] rec_dst_q, rec_dst_d;
    logic [31:0] rec_data_q, rec_data_d;
    logic [1:0]  format_q, format_d;
    logic [3:0]  error_q, error_d;
    logic        record_valid_q, record_valid_d;
    logic [15:0] rec_count_q, rec_count_d;
    logic [15:0] err_count_q, err_count_d;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic        is_dec;
    logic        is_hex_letter;
    logic        is_hex;
    logic [3:0]  nibble;
    logic [31:0] digit32;

    always_comb begin
        is_dec        = (char >= 8'h30) && (char <= 8'h39);
        is_hex_letter = (char >= 8'h61) && (char <= 8'h66);
        is_hex        = is_dec || is_hex_letter;
        // '0'..'9' carry their value in the low nibble; 'a'..'f' are 0x61..0x66.
        nibble        = is_hex_letter ? (char[3:0] + 4'd9) : char[3:0];
        digit32       = {28'd0, char[3:0]};
    end

    // ------------------------------------------------------------------
    // Semantic checks on the accumulated fields (used when '#' lands)
    // ------------------------------------------------------------------
    logic [15:0] half_freq_m1;
    logic [3:0]  err_vec;

    always_comb begin
        half_freq_m1 = (freq >> 1) - 16'd1;
        err_vec      = 4'd0;
        // Time must be a multiple of freq/2; masking works since freq is 2^n.
        err_vec[0]   = (freq >= 16'd2) &&
                       ((time_q & {16'd0, half_freq_m1}) != 32'd0);
        // A leading 1 on both sides keeps the lower-bound compare meaningful
        // even when the bound is zero.
        err_vec[1]   = ({1'b1, pc_q} < {1'b1, PC_LO}) || (pc_q > PC_HI) ||
                       (pc_q[1:0] != 2'b00);
        err_vec[2]   = is_mem_q &&
                       (({1'b1, dst_q} < {1'b1, DM_LO}) || (dst_q > DM_HI) ||
                        (dst_q[1:0] != 2'b00));
        err_vec[3]   = !is_mem_q && (dst_q > 32'(GRF_MAX));
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_mem_d       = is_mem_q;
        time_d         = time_q;
        pc_d           = pc_q;
        dst_d          = dst_q;
        data_d         = data_q;
        rec_time_d     = rec_time_q;
        rec_pc_d       = rec_pc_q;
        rec_dst_d      = rec_dst_q;
        rec_data_d     = rec_data_q;
        format_d       = format_q;
        error_d        = error_q;
        record_valid_d = 1'b0;
        rec_count_d    = rec_count_q;
        err_count_d    = err_count_q;

        if (char_valid) begin
            // Any accepted char leaves DONE, so the record flags drop here and
            // are raised again only when '#' completes a line.
            format_d = 2'b00;
            error_d  = 4'd0;

            if (char == 8'h5E) begin
                // '^' restarts a line from anywhere, dropping partial fields.
                state_d  = CARET;
                cnt_d    = 8'd0;
                is_mem_d = 1'b0;
                time_d   = 32'd0;
                pc_d     = 32'd0;
                dst_d    = 32'd0;
                data_d   = 32'd0;
            end else begin
                state_d = IDLE;  // anything not matched below is illegal
                case (state_q)
                    CARET: begin
                        if (is_dec) begin
                            state_d = TIME;
                            cnt_d   = 8'd1;
                            time_d  = time_q * 32'd10 + digit32;
                        end
                    end
                    TIME: begin
                        if (is_dec && (cnt_q < 8'(TIME_DIGITS))) begin
                            state_d = TIME;
                            cnt_d   = cnt_q + 8'd1;
                            time_d  = time_q * 32'd10 + digit32;
                        end else if (char == 8'h40) begin  // '@'
                            state_d = AT;
                        end
                    end
                    AT: begin
                        if (is_hex) begin
                            state_d = PC;
                            cnt_d   = 8'd1;
                            pc_d    = {pc_q[27:0], nibble};
                        end
                    end
                    PC: begin
                        if (is_hex && (cnt_q < HEX_DIGITS)) begin
                            state_d = PC;
                            cnt_d   = cnt_q + 8'd1;
                            pc_d    = {pc_q[27:0], nibble};
                        end else if ((char == 8'h3A) && (cnt_q == HEX_DIGITS)) begin
                            state_d = COLON;
                        end
                    end
                    COLON: begin
                        if (char == 8'h20) begin
                            state_d = COLON;
                        end else if (char == 8'h24) begin  // '$'
                            state_d  = DOLLAR;
                            is_mem_d = 1'b0;
                        end else if (char == 8'h2A) begin  // '*'
                            state_d  = STAR;
                            is_mem_d = 1'b1;
                        end
                    end
                    DOLLAR: begin
                        if (is_dec) begin
                            state_d = REG;
                            cnt_d   = 8'd1;
                            dst_d   = dst_q * 32'd10 + digit32;
                        end
                    end
                    REG: begin
                        if (is_dec && (cnt_q < 8'(REG_DIGITS))) begin
                            state_d = REG;
                            cnt_d   = cnt_q + 8'd1;
                            dst_d   = dst_q * 32'd10 + digit32;
                        end else if (char == 8'h20) begin
                            state_d = SP1;
                        end else if (char == 8'h3C) begin  // '<'
                            state_d = LT;
                        end
                    end
                    STAR: begin
                        if (is_hex) begin
                            state_d = ADDR;
                            cnt_d   = 8'd1;
                            dst_d   = {dst_q[27:0], nibble};
                        end
                    end
                    ADDR: begin
                        if (is_hex && (cnt_q < HEX_DIGITS)) begin
                            state_d = ADDR;
                            cnt_d   = cnt_q + 8'd1;
                            dst_d   = {dst_q[27:0], nibble};
                        end else if ((char == 8'h20) && (cnt_q == HEX_DIGITS)) begin
                            state_d = SP1;
                        end else if ((char == 8'h3C) && (cnt_q == HEX_DIGITS)) begin
                            state_d = LT;
                        end
                    end
                    SP1: begin
                        if (char == 8'h20) begin
                            state_d = SP1;
                        end else if (char == 8'h3C) begin
                            state_d = LT;
                        end
                    end
                    LT: begin
                        if (char == 8'h3D) begin  // '='
                            state_d = EQ;
                        end
                    end
                    EQ: begin
                        if (char == 8'h20) begin
                            state_d = EQ;
                        end else if (is_hex) begin
                            state_d = DATA;
                            cnt_d   = 8'd1;
                            data_d  = {data_q[27:0], nibble};
                        end
                    end
                    DATA: begin
                        if (is_hex && (cnt_q < HEX_DIGITS)) begin
                            state_d = DATA;
                            cnt_d   = cnt_q + 8'd1;
                            data_d  = {data_q[27:0], nibble};
                        end else if ((char == 8'h23) && (cnt_q == HEX_DIGITS)) begin
                            // '#' completes the line: publish the record.
                            state_d        = DONE;
                            rec_time_d     = time_q;
                            rec_pc_d       = pc_q;
                            rec_dst_d      = dst_q;
                            rec_data_d     = data_q;
                            format_d       = is_mem_q ? 2'b10 : 2'b01;
                            error_d        = err_vec;
                            record_valid_d = 1'b1;
                            rec_count_d    = rec_count_q + 16'd1;
                            if ((err_vec != 4'd0) && (err_count_q != 16'hFFFF)) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;  // IDLE and DONE fall back to IDLE
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            is_mem_q       <= 1'b0;
            time_q         <= 32'd0;
            pc_q           <= 32'd0;
            dst_q          <= 32'd0;
            data_q         <= 32'd0;
            rec_time_q     <= 32'd0;
            rec_pc_q       <= 32'd0;
            rec_dst_q      <= 32'd0;
            rec_data_q     <= 32'd0;
            format_q       <= 2'b00;
            error_q        <= 4'd0;
            record_valid_q <= 1'b0;
            rec_count_q    <= 16'd0;
            err_count_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            is_mem_q       <= is_mem_d;
            time_q         <= time_d;
            pc_q           <= pc_d;
            dst_q          <= dst_d;
            data_q         <= data_d;
            rec_time_q     <= rec_time_d;
            rec_pc_q       <= rec_pc_d;
            rec_dst_q      <= rec_dst_d;
            rec_data_q     <= rec_data_d;
            format_q       <= format_d;
            error_q        <= error_d;
            record_valid_q <= record_valid_d;
            rec_count_q    <= rec_count_d;
            err_count_q    <= err_count_d;
        end
    end

    assign format_type  = format_q;
    assign error_code   = error_q;
    assign record_valid = record_valid_q;
    assign rec_time     = rec_time_q;
    assign rec_pc       = rec_pc_q;
    assign rec_dst      = rec_dst_q;
    assign rec_data     = rec_data_q;
    assign rec_count    = rec_count_q;
    assign err_count    = err_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_checker
//
// Drives trace lines character by character into trace_checker. Each line
// expected to be accepted pushes its record (fields, format, error flags and
// resulting counter values) onto exp_q; a monitor pops and compares whenever
// record_valid pulses. Scenario tasks add their own inline checks.
// -----------------------------------------------------------------------------
module tb_trace_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic        record_valid;
    logic [31:0] rec_time;
    logic [31:0] rec_pc;
    logic [31:0] rec_dst;
    logic [31:0] rec_data;
    logic [15:0] rec_count;
    logic [15:0] err_count;
    logic [3:0]  dbg_state;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_DONE = 4'd14;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    trace_checker dut (
        .clk          (clk),
        .reset        (reset),
        .char_valid   (char_valid),
        .char         (char),
        .freq         (freq),
        .format_type  (format_type),
        .error_code   (error_code),
        .record_valid (record_valid),
        .rec_time     (rec_time),
        .rec_pc       (rec_pc),
        .rec_dst      (rec_dst),
        .rec_data     (rec_data),
        .rec_count    (rec_count),
        .err_count    (err_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [31:0] t;
        logic [31:0] pc;
        logic [31:0] dst;
        logic [31:0] data;
        logic [15:0] rc;
        logic [15:0] ec;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_rc = 16'd0;
    logic [15:0] exp_ec = 16'd0;

    // Reference error flags, written from the field rules directly.
    function automatic logic [3:0] model_err(input logic [31:0] t, input logic [31:0] pc,
                                             input logic [31:0] dst, input bit is_mem,
                                             input logic [15:0] f);
        logic [3:0] e;
        e    = 4'd0;
        e[0] = (f >= 16'd2) && ((t % {16'd0, f / 16'd2}) != 32'd0);
        e[1] = (pc < 32'h3000) || (pc > 32'h4FFC) || ((pc % 32'd4) != 32'd0);
        e[2] = is_mem && ((dst > 32'h2FFC) || ((dst % 32'd4) != 32'd0));
        e[3] = !is_mem && (dst > 32'd31);
        return e;
    endfunction

    task automatic push_expected(input logic [31:0] t, input logic [31:0] pc,
                                 input logic [31:0] dst, input logic [31:0] data,
                                 input bit is_mem);
        rec_t r;
        r.fmt  = is_mem ? 2'b10 : 2'b01;
        r.err  = model_err(t, pc, dst, is_mem, freq);
        r.t    = t;
        r.pc   = pc;
        r.dst  = dst;
        r.data = data;
        exp_rc = exp_rc + 16'd1;
        if (r.err != 4'd0 && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
        r.rc   = exp_rc;
        r.ec   = exp_ec;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && record_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_record: got record_valid=1 time=%0d, required no record", rec_time);
            end else begin
                mon_e = exp_q.pop_front();
                tests++; if (format_type !== mon_e.fmt) begin fails++; $display("FAIL rec_format: got %b required %b", format_type, mon_e.fmt); end
                tests++; if (error_code !== mon_e.err) begin fails++; $display("FAIL rec_error: got %b required %b", error_code, mon_e.err); end
                tests++; if (rec_time !== mon_e.t) begin fails++; $display("FAIL rec_time: got %0d required %0d", rec_time, mon_e.t); end
                tests++; if (rec_pc !== mon_e.pc) begin fails++; $display("FAIL rec_pc: got %h required %h", rec_pc, mon_e.pc); end
                tests++; if (rec_dst !== mon_e.dst) begin fails++; $display("FAIL rec_dst: got %h required %h", rec_dst, mon_e.dst); end
                tests++; if (rec_data !== mon_e.data) begin fails++; $display("FAIL rec_data: got %h required %h", rec_data, mon_e.data); end
                tests++; if (rec_count !== mon_e.rc) begin fails++; $display("FAIL rec_count: got %0d required %0d", rec_count, mon_e.rc); end
                tests++; if (err_count !== mon_e.ec) begin fails++; $display("FAIL err_count: got %0d required %0d", err_count, mon_e.ec); end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; each char is taken on
    // the following edge, then optional idle cycles follow.
    task automatic send_char(input logic [7:0] c, input int gap);
        char_valid = 1'b1;
        char       = c;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char       = 8'h00;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_line(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    function automatic string spaces(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    // Bounded wait for the monitor to consume every pending record.
    task automatic wait_drain(input string name);
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_record_missing: %0d records outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_counters(input string name);
        tests++;
        if (rec_count !== exp_rc) begin fails++; $display("FAIL %s_rec_count: got %0d required %0d", name, rec_count, exp_rc); end
        tests++;
        if (err_count !== exp_ec) begin fails++; $display("FAIL %s_err_count: got %0d required %0d", name, err_count, exp_ec); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset      = 1'b0;
        char_valid = 1'b1;   // reset must win over a valid char
        char       = 8'h5E;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
        tests++; if (format_type !== 2'b00) begin fails++; $display("FAIL reset_format: got %b required 00", format_type); end
        tests++; if (error_code !== 4'd0) begin fails++; $display("FAIL reset_error: got %b required 0000", error_code); end
        tests++; if (record_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", record_valid); end
        tests++; if ({rec_time, rec_pc, rec_dst, rec_data} !== 128'd0) begin fails++; $display("FAIL reset_rec: got %h required 0", {rec_time, rec_pc, rec_dst, rec_data}); end
        check_counters("reset");
        char_valid = 1'b0;
        char       = 8'h00;
        reset      = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reg_record();
        freq = 16'd4;
        push_expected(32'd10, 32'h3004, 32'd5, 32'h0000000a, 1'b0);
        send_line("^10@00003004: $5 <= 0000000a#", 0);
        wait_drain("reg_record");
        // DONE holds with no input; record_valid is a single pulse.
        tests++; if (dbg_state !== ST_DONE) begin fails++; $display("FAIL reg_hold_state: got %0d required %0d", dbg_state, ST_DONE); end
        tests++; if (format_type !== 2'b01) begin fails++; $display("FAIL reg_hold_format: got %b required 01", format_type); end
        tests++; if (error_code !== 4'd0) begin fails++; $display("FAIL reg_hold_error: got %b required 0000", error_code); end
        tests++; if (record_valid !== 1'b0) begin fails++; $display("FAIL reg_hold_valid: got %b required 0", record_valid); end
        tests++; if (rec_dst !== 32'd5) begin fails++; $display("FAIL reg_hold_dst: got %0d required 5", rec_dst); end
        check_counters("reg_record");
    endtask

    task automatic test_mem_record();
        freq = 16'd4;
        push_expected(32'd7, 32'h2ffe, 32'h3000, 32'h12345678, 1'b1);
        send_line("^7@00002ffe: *00003000 <= 12345678#", 0);
        wait_drain("mem_record");
        tests++; if (error_code !== 4'b0111) begin fails++; $display("FAIL mem_error: got %b required 0111", error_code); end
        tests++; if (format_type !== 2'b10) begin fails++; $display("FAIL mem_format: got %b required 10", format_type); end
        check_counters("mem_record");
        // Next non-'^' char leaves DONE and clears the flags.
        send_char(8'h20, 0);
        tests++; if (format_type !== 2'b00 || error_code !== 4'd0 || dbg_state !== ST_IDLE) begin
            fails++; $display("FAIL mem_leave_done: got fmt=%b err=%b state=%0d required 00/0000/0", format_type, error_code, dbg_state);
        end
    endtask

    task automatic test_reg_range();
        freq = 16'd1;
        push_expected(32'd1, 32'h3000, 32'd32, 32'd0, 1'b0);
        send_line("^1@00003000: $32 <= 00000000#", 0);
        wait_drain("reg_range");
        tests++; if (error_code !== 4'b1000) begin fails++; $display("FAIL reg_range_error: got %b required 1000", error_code); end
        send_line("^1@00003000: $123 <= 00000000#", 0);
        repeat (2) begin @(posedge clk); #1; end
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL reg3_state: got %0d required %0d", dbg_state, ST_IDLE); end
        tests++; if (format_type !== 2'b00) begin fails++; $display("FAIL reg3_format: got %b required 00", format_type); end
        check_counters("reg3");
    endtask

    task automatic test_restart();
        freq = 16'd4;
        push_expected(32'd5, 32'h3000, 32'd1, 32'd1, 1'b0);
        send_line("^12@0000^5@00003000: $1 <= 00000001#", 0);
        wait_drain("restart");
        send_line("^9@00003000: $1 <= 0000000A#", 0);
        repeat (2) begin @(posedge clk); #1; end
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL upper_state: got %0d required %0d", dbg_state, ST_IDLE); end
        tests++; if (rec_time !== 32'd5) begin fails++; $display("FAIL upper_rec_time: got %0d required 5", rec_time); end
        check_counters("upper");
    endtask

    task automatic test_illegal();
        string bad[4];
        bad[0] = "^12345@00003000: $1 <= 00000001#";
        bad[1] = "^1@0000300: $1 <= 00000001#";
        bad[2] = "^1@00003000: $1 <= 0000001#";
        bad[3] = "^1@00003000: *000030000 <= 00000001#";
        for (int i = 0; i < 4; i++) begin
            send_line(bad[i], 0);
            @(posedge clk); #1;
            tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL illegal%0d_state: got %0d required %0d", i, dbg_state, ST_IDLE); end
            check_counters("illegal");
        end
        // Boundary: maximum-length time field and no optional spaces.
        push_expected(32'd9999, 32'h4ffc, 32'd31, 32'hdeadbeef, 1'b0);
        send_line("^9999@00004ffc:$31<=deadbeef#", 0);
        wait_drain("boundary");
    endtask

    task automatic test_gaps();
        freq = 16'd4;
        push_expected(32'd10, 32'h3004, 32'd5, 32'h0000000a, 1'b0);
        send_line("^10@00003004: $5 <= 0000000a#", 4);
        wait_drain("gaps");
        tests++; if (format_type !== 2'b01 || error_code !== 4'd0) begin
            fails++; $display("FAIL gaps_flags: got fmt=%b err=%b required 01/0000", format_type, error_code);
        end
        check_counters("gaps");
    endtask

    task automatic test_reset_mid();
        send_line("^3@00003000: $2 <= 0000", 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        exp_rc = 16'd0;
        exp_ec = 16'd0;
        tests++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL mid_reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
        tests++; if ({rec_time, rec_pc, rec_dst, rec_data} !== 128'd0 || format_type !== 2'b00) begin
            fails++; $display("FAIL mid_reset_outputs: got rec=%h fmt=%b required 0", {rec_time, rec_pc, rec_dst, rec_data}, format_type);
        end
        check_counters("mid_reset");
        // The tail of the interrupted line must not form a record.
        send_line("1234#", 0);
        check_counters("mid_tail");
        freq = 16'd4;
        push_expected(32'd10, 32'h3004, 32'd5, 32'h0000000a, 1'b0);
        send_line("^10@00003004: $5 <= 0000000a#", 0);
        wait_drain("after_reset");
        // Reset while in DONE.
        reset = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        exp_rc = 16'd0;
        exp_ec = 16'd0;
        tests++; if (format_type !== 2'b00 || dbg_state !== ST_IDLE) begin
            fails++; $display("FAIL done_reset: got fmt=%b state=%0d required 00/0", format_type, dbg_state);
        end
        check_counters("done_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs[6];
        logic [31:0] addrs[5];
        pcs[0] = 32'h3000; pcs[1] = 32'h4ffc; pcs[2] = 32'h4ffd;
        pcs[3] = 32'h2ffc; pcs[4] = 32'h5000; pcs[5] = 32'h3abc;
        addrs[0] = 32'h0;  addrs[1] = 32'h2ffc; addrs[2] = 32'h3000;
        addrs[3] = 32'h2ffe; addrs[4] = 32'h0100;
        for (int n = 0; n < 12; n++) begin
            logic [31:0] t, pc, dst, data;
            bit          is_mem;
            string       field, line;
            t      = 32'($urandom_range(0, 9999));
            pc     = (n % 3 == 2) ? $urandom() : pcs[$urandom_range(0, 5)];
            is_mem = 1'($urandom_range(0, 1));
            dst    = is_mem ? addrs[$urandom_range(0, 4)] : 32'($urandom_range(0, 40));
            data   = $urandom();
            freq   = 16'(1 << $urandom_range(0, 6));
            field  = is_mem ? $sformatf("*%08x", dst) : $sformatf("$%0d", dst);
            line   = $sformatf("^%0d@%08x:%s%s%s<=%s%08x#", t, pc,
                               spaces($urandom_range(0, 2)), field,
                               spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), data);
            push_expected(t, pc, dst, data, is_mem);
            send_line(line, (n % 4 == 3) ? 2 : 0);
        end
        wait_drain("back_to_back");
        check_counters("back_to_back");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset      = 1'b0;
        char_valid = 1'b0;
        char       = 8'h00;
        freq       = 16'd4;
        @(posedge clk); #1;
        test_reset();
        test_reg_record();
        test_mem_record();
        test_reg_range();
        test_restart();
        test_illegal();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        repeat (2) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
